lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side companion to the 32-bit LFSR random-number generator. It consumes the generator's word stream, self-synchronises by seeding a local LFSR from a received word, predicts every following word, and flags and counts mismatches. Use it as a built-in self-test monitor on any link or FIFO that carries the generator's output, and in benches as a hardware scoreboard.

## Interface
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock (≥1).
- LOSS_COUNT, 3: consecutive mispredictions while locked that drop lock (≥1).
- CNT_W, 16: width of the error and word counters.
- clock  in  1  rising-edge system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data carries one generator word this cycle.
- in_data  in  32  received word.
- clear  in  1  synchronous clear of err_count and word_count; lock state is unaffected.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse for each mismatching word while locked.
- err_count  out  CNT_W  saturating count of err_pulse events.
- word_count  out  CNT_W  saturating count of words checked while locked.

## Operation
- Step function for one word per generator step: next(w) = {w[30:0], w[31]^w[21]^w[1]^w[0]}, which is polynomial x^32+x^22+x^2+x+1.
- Internal registers: pred[31:0], match_cnt, miss_cnt, state.
- SEARCH: on in_valid with in_data ≠ 0, set pred = next(in_data) and match_cnt = 0, then go to VERIFY. A zero word is ignored because it is the lock-up state.
- VERIFY, on in_valid:
  - If in_data == pred, then match_cnt+1 and pred = next(pred). When match_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt = 0.
  - If in_data ≠ pred, reseed (pred = next(in_data), match_cnt = 0) and stay in VERIFY. If in_data == 0, go to SEARCH instead.
- LOCKED, on every in_valid:
  - pred = next(pred) regardless of the comparison result, so a single corrupted word causes exactly one error.
  - word_count+1.
  - On a match, set miss_cnt = 0.
  - On a mismatch, set err_pulse, increment err_count, and increment miss_cnt. When miss_cnt reaches LOSS_COUNT, go to SEARCH.
- Cycles without in_valid change nothing and are not errors.
- Counters saturate at 2^CNT_W−1; they do not wrap.
- If clear and an increment occur in the same cycle, clear wins and the result is 0.
- Counters keep their values across a loss of lock.

## Timing
- Reset values: state = SEARCH, pred = 0, locked = 0, err_pulse = 0, err_count = 0, word_count = 0.
- Reset is asynchronous assert and synchronous deassert (assumed external); it is honoured mid-stream at any time.
- All outputs are registered. The response to a word sampled on edge N is visible after edge N, so latency is 1 cycle.
- locked rises on the edge that accepts the LOCK_COUNT-th matching word. With the default, the 1st word seeds and words 2–5 match, so locked is high after the 5th accepted word.
- locked falls on the edge that accepts the LOSS_COUNT-th consecutive mismatch. That word still produces err_pulse and is counted.
- Back-to-back in_valid is supported at 1 word per cycle with no stall; there is no ready signal.

## Structure
- Package lfsr_pkg holds:
  - the tap constants (31, 21, 1, 0);
  - the function lfsr_next(w), shared with the generator so the two cannot diverge;
  - the state enum {SEARCH, VERIFY, LOCKED}.
- One sub-module is natural: sat_counter (parameter W; inputs inc and clr; output value, saturating), instantiated twice.

## Test plan
- Lock: reset, then feed 0x00000001, 0x00000003, 0x00000006, 0x0000000D, 0x0000001B. locked = 1 after the 5th word; err_count = 0, word_count = 0.
- Single corruption: once locked, feed the correct stream with one word XOR 0x1. Expect exactly one err_pulse, err_count = 1, locked stays 1, and no further errors.
- Loss: once locked, feed 3 consecutive wrong words (0xDEADBEEF ×3). Expect err_count = 3 and locked = 0 after the 3rd. Then a correct-sequence restart re-locks after 5 words.
- Zero and gaps:
  - In SEARCH, in_data = 0 leaves state in SEARCH.
  - In LOCKED, in_valid held low for 10 cycles produces no errors, and the stream resumes matching.
- Saturation and clear: force 2^16+5 checked words. Expect word_count = 0xFFFF. Pulse clear in the same cycle as a valid word; expect word_count = 0.
- Reset mid-operation: assert reset_n = 0 while LOCKED with err_count = 2. All outputs return to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR generator and its stream checker.
// Holds the tap set, the one-step function and the checker state encoding.
package lfsr_pkg;

    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, Fibonacci form, shifting left
    function automatic logic [31:0] lfsr_next(input logic [31:0] w);
        return {w[30:0], w[TAP_A] ^ w[TAP_B] ^ w[TAP_C] ^ w[TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + W'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker: seeds from the stream, predicts each next word,
// declares lock after a run of hits and counts mismatches while locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pred;
    logic [31:0]   w_pred_nxt;
    logic [MW-1:0] r_match_cnt;
    logic [MW-1:0] w_match_nxt;
    logic [MW-1:0] w_match_inc;
    logic [LW-1:0] r_miss_cnt;
    logic [LW-1:0] w_miss_nxt;
    logic [LW-1:0] w_miss_inc;
    logic          r_locked;
    logic          r_err_pulse;
    logic          w_err;
    logic          w_word_inc;
    logic          w_hit;
    logic          w_zero;

    assign w_hit       = (in_data == r_pred);
    assign w_zero      = (in_data == '0);
    assign w_match_inc = r_match_cnt + MW'(1);
    assign w_miss_inc  = r_miss_cnt + LW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SEARCH;
            r_pred      <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err       = 1'b0;
        w_word_inc  = 1'b0;
        if (in_valid) begin
            unique case (r_state)
                // an all-zero word is the LFSR lock-up state: never seed on it
                SEARCH: begin
                    if (!w_zero) begin
                        w_pred_nxt  = lfsr_next(in_data);
                        w_match_nxt = '0;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_hit) begin
                        w_match_nxt = w_match_inc;
                        w_pred_nxt  = lfsr_next(r_pred);
                        if (w_match_inc == MW'(LOCK_COUNT)) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else if (w_zero) begin
                        w_match_nxt = '0;
                        w_state_nxt = SEARCH;
                    end else begin
                        w_pred_nxt  = lfsr_next(in_data);
                        w_match_nxt = '0;
                    end
                end
                // keep stepping on misses so one bad word costs one error
                LOCKED: begin
                    w_pred_nxt = lfsr_next(r_pred);
                    w_word_inc = 1'b1;
                    if (w_hit) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err      = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == LW'(LOSS_COUNT)) begin
                            w_state_nxt = SEARCH;
                        end
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (w_err),
        .clr    (clear),
        .value  (err_count)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_word_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (w_word_inc),
        .clr    (clear),
        .value  (word_count)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, corruption, loss, zeros, gaps,
// clear, saturation and asynchronous reset.
module tb_lfsr_checker;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        clr;
        logic        exp_locked;
        logic        exp_err;
        logic [15:0] exp_errc;
        logic [15:0] exp_wordc;
    } vec_t;

    vec_t tbl [24];

    lfsr_checker #(
        .LOCK_COUNT(4),
        .LOSS_COUNT(3),
        .CNT_W     (16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .word_count(word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] tb_next(input logic [31:0] w);
        logic fb;
        fb = ^(w & 32'h8020_0003);
        return (w << 1) | {31'd0, fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic c);
        @(negedge clock);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic lock_from(input logic [31:0] seed, output logic [31:0] last);
        logic [31:0] w;
        w = seed;
        step(1'b1, w, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = tb_next(w);
            step(1'b1, w, 1'b0);
        end
        last = w;
    endtask

    initial begin
        logic [31:0] w;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;

        tbl[0]  = '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[2]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[3]  = '{1'b1, 32'h0000_000D, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[4]  = '{1'b1, 32'h0000_001B, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[5]  = '{1'b1, 32'h0000_0036, 1'b0, 1'b1, 1'b0, 16'd0, 16'd1};
        tbl[6]  = '{1'b1, 32'h0000_006C, 1'b0, 1'b1, 1'b1, 16'd1, 16'd2};
        tbl[7]  = '{1'b1, 32'h0000_00DB, 1'b0, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[8]  = '{1'b1, 32'h0000_01B6, 1'b0, 1'b1, 1'b0, 16'd1, 16'd4};
        tbl[9]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'd1, 16'd4};
        tbl[10] = '{1'b1, 32'h0000_036D, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[11] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
        tbl[12] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 16'd2, 16'd2};
        tbl[13] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 16'd3, 16'd3};
        for (int i = 14; i < 19; i++)
            tbl[i] = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3};
        tbl[19] = '{1'b1, 32'h0000_06DB, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3};
        tbl[20] = '{1'b1, 32'h0000_0DB6, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3};
        tbl[21] = '{1'b1, 32'h0000_1B6D, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3};
        tbl[22] = '{1'b1, 32'h0000_36DB, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3};
        tbl[23] = '{1'b1, 32'h0000_6DB6, 1'b0, 1'b1, 1'b0, 16'd3, 16'd3};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err", {31'd0, err_pulse}, 32'd0);
        chk("rst_errc", {16'd0, err_count}, 32'd0);
        chk("rst_wordc", {16'd0, word_count}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].valid, tbl[i].data, tbl[i].clr);
            chk($sformatf("v%0d_locked", i), {31'd0, locked},
                {31'd0, tbl[i].exp_locked});
            chk($sformatf("v%0d_err", i), {31'd0, err_pulse},
                {31'd0, tbl[i].exp_err});
            chk($sformatf("v%0d_errc", i), {16'd0, err_count},
                {16'd0, tbl[i].exp_errc});
            chk($sformatf("v%0d_wordc", i), {16'd0, word_count},
                {16'd0, tbl[i].exp_wordc});
        end

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk($sformatf("gap%0d_err", i), {31'd0, err_pulse}, 32'd0);
        end
        chk("gap_locked", {31'd0, locked}, 32'd1);
        step(1'b1, tb_next(32'h0000_6DB6), 1'b0);
        chk("resume_err", {31'd0, err_pulse}, 32'd0);
        chk("resume_errc", {16'd0, err_count}, 32'd3);
        chk("resume_wordc", {16'd0, word_count}, 32'd4);

        do_reset();
        lock_from(32'h1234_5678, w);
        chk("l2_locked", {31'd0, locked}, 32'd1);
        w = tb_next(w);
        step(1'b1, w ^ 32'h1, 1'b0);
        w = tb_next(w);
        step(1'b1, w, 1'b0);
        w = tb_next(w);
        step(1'b1, w ^ 32'h1, 1'b0);
        chk("pre_rst_errc", {16'd0, err_count}, 32'd2);
        chk("pre_rst_wordc", {16'd0, word_count}, 32'd3);
        chk("pre_rst_locked", {31'd0, locked}, 32'd1);
        chk("pre_rst_err", {31'd0, err_pulse}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_err", {31'd0, err_pulse}, 32'd0);
        chk("arst_errc", {16'd0, err_count}, 32'd0);
        chk("arst_wordc", {16'd0, word_count}, 32'd0);

        do_reset();
        lock_from(32'h0000_0001, w);
        for (int i = 0; i < 65541; i++) begin
            w = tb_next(w);
            step(1'b1, w, 1'b0);
        end
        chk("sat_wordc", {16'd0, word_count}, 32'h0000_FFFF);
        chk("sat_errc", {16'd0, err_count}, 32'd0);
        chk("sat_locked", {31'd0, locked}, 32'd1);
        w = tb_next(w);
        step(1'b1, w, 1'b1);
        chk("clr_wordc", {16'd0, word_count}, 32'd0);
        w = tb_next(w);
        step(1'b1, w, 1'b0);
        chk("post_clr_wordc", {16'd0, word_count}, 32'd1);
        chk("post_clr_locked", {31'd0, locked}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
